ack_sequence_controller: RTL and testbench
==========================================

// Module: ack_sequence_controller
// PURPOSE
//  Upstream sequencer for AcknowledgeModule. Tracks INTA# pulses and poll reads and
//  produces control_state (CTL_READY/ACK1/ACK2/ACK3/POLL). Latches the winning request
//  at ACK1 (interrupt_when_ack1) and pulses in-service set/end strobes. Resolves the
//  cascade handshake (CAS2:0 drive/compare) into cascade_output_ack_2_3.
// PARAMETERS
//  none (state codes come from the shared include)
// PORTS
//  clock                       in   1  system clock; single clock domain
//  reset_n                     in   1  asynchronous, active-low reset
//  interrupt_acknowledge_n     in   1  INTA#, double-flop synchronised internally
//  read                        in   1  bus read strobe, active-high
//  write_initial_command_word_1 in  1  ICW1 write pulse; restarts the sequencer
//  poll_command                in   1  one-cycle pulse: OCW3 written with P=1
//  u8086_or_mcs80_config       in   1  0 = 8086 (2 INTA), 1 = MCS-80 (3 INTA)
//  single_or_cascade_config    in   1  1 = single device, no cascade handshake
//  cascade_slave               in   1  1 = this device is a slave (SP#/EN# low)
//  cascade_device_config       in   8  ICW3 master: IRs carrying slaves
//  cascade_id                  in   3  ICW3 slave: own identity
//  cascade_in                  in   3  CAS2:0 pins as received
//  interrupt                   in   8  one-hot winner from priority resolver
//  control_state               out  3  current state, consumed by AcknowledgeModule
//  interrupt_when_ack1         out  8  one-hot request frozen at ACK1 entry
//  latch_in_service            out  1  1-cycle pulse: set ISR bit of interrupt_when_ack1
//  end_of_acknowledge_sequence out  1  1-cycle pulse on last INTA# rising edge
//  end_of_poll_command         out  1  1-cycle pulse on poll read completion
//  freeze                      out  1  1 whenever control_state != CTL_READY
//  cascade_output_ack_2_3      out  1  1 = this device drives data in ACK2/ACK3
//  cascade_out                 out  3  CAS2:0 value driven as master
//  cascade_io                  out  1  1 = master drives cascade_out this cycle
// BEHAVIOUR
//  Reset: control_state=CTL_READY; all other outputs 0.
//  Edges: inta_fall/inta_rise and read_fall from synchronised history; 1-cycle pulses.
//  Transitions (register update on clock; ICW1 write beats everything, forces CTL_READY,
//   clears interrupt_when_ack1, emits no end strobes):
//   CTL_READY: poll_command -> POLL; else inta_fall -> ACK1. Both same cycle: POLL wins.
//   ACK1: inta_rise -> ACK2.
//   ACK2: inta_rise -> 8086: CTL_READY + end_of_acknowledge_sequence; MCS-80: ACK3.
//   ACK3: inta_rise -> CTL_READY + end_of_acknowledge_sequence.
//   POLL: read_fall -> CTL_READY + end_of_poll_command.
//  Latch: on CTL_READY->ACK1, and on read rising edge in POLL,
//   interrupt_when_ack1<=interrupt and latch_in_service pulses, only if interrupt!=0.
//   interrupt==0 at ACK1 stays 0 (spurious; no ISR set; sequence still completes).
//  Cascade (evaluated on ACK1 inta_rise, held until CTL_READY):
//   single mode -> cascade_output_ack_2_3=1.
//   master: hit = |(interrupt_when_ack1 & cascade_device_config); hit -> 0, cascade_io=1,
//    cascade_out=bit2num(interrupt_when_ack1) from ACK1 entry to sequence end; else 1.
//   slave: cascade_output_ack_2_3 = (cascade_in == cascade_id).
//  Before evaluation and in CTL_READY: cascade_output_ack_2_3=0, cascade_io=0, cascade_out=0.
//  INTA# held low indefinitely: state holds; glitches under 2 clocks may be missed.
//  Async reset mid-sequence: immediate CTL_READY, no end strobes.
// STRUCTURE
//  Shared include control_state_defs.vh: CTL_READY=3'd0, ACK1=3'd1, ACK2=3'd2,
//   ACK3=3'd3, POLL=3'd4; function bit2num (8-bit one-hot -> 3-bit index).
//  Sub-module edge_sync_detector: 2-flop synchroniser + rise/fall pulses;
//   instantiated for INTA# and read.
// TESTING
//  8086 single: interrupt=8'h04, two INTA# pulses -> states 0,1,2,0; latch_in_service
//   once with interrupt_when_ack1=8'h04; end_of_acknowledge_sequence on 2nd rise.
//  MCS-80: three INTA# pulses -> 0,1,2,3,0; end pulse only on 3rd rise.
//  Master, cascade_device_config=8'h08, interrupt=8'h08 -> cascade_io=1,
//   cascade_out=3'd3, cascade_output_ack_2_3=0 in ACK2.
//  Slave id=3'd5: cascade_in=5 -> ack_2_3=1; cascade_in=2 -> 0.
//  poll_command + simultaneous inta_fall -> POLL; read pulse -> latch, end_of_poll_command.
//  ICW1 write in ACK2 / reset_n low in ACK3 -> CTL_READY next edge / immediately, no end strobes.

Source files
------------

// File: rtl/ack_sequence_controller_pkg.sv
// Shared state codes and helpers for the INTA#/poll acknowledge sequencer.
// Pure declarations; no latency or backpressure.
package ack_sequence_controller_pkg;

    typedef enum logic [2:0] {
        CTL_READY = 3'd0,
        ACK1      = 3'd1,
        ACK2      = 3'd2,
        ACK3      = 3'd3,
        POLL      = 3'd4
    } ctl_state_t;

    // One-hot to index; the resolver guarantees at most one bit set.
    function automatic logic [2:0] bit2num(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ack_sequence_controller_if.sv
// Bus bundle between the acknowledge sequencer and its surroundings.
// master = side driving the bus/config inputs, slave = the sequencer itself.
interface ack_sequence_controller_if;
    import ack_sequence_controller_pkg::*;

    logic       interrupt_acknowledge_n;
    logic       read;
    logic       write_initial_command_word_1;
    logic       poll_command;
    logic       u8086_or_mcs80_config;
    logic       single_or_cascade_config;
    logic       cascade_slave;
    logic [7:0] cascade_device_config;
    logic [2:0] cascade_id;
    logic [2:0] cascade_in;
    logic [7:0] interrupt;

    ctl_state_t control_state;
    logic [7:0] interrupt_when_ack1;
    logic       latch_in_service;
    logic       end_of_acknowledge_sequence;
    logic       end_of_poll_command;
    logic       freeze;
    logic       cascade_output_ack_2_3;
    logic [2:0] cascade_out;
    logic       cascade_io;

    modport master (
        output interrupt_acknowledge_n, read, write_initial_command_word_1, poll_command,
               u8086_or_mcs80_config, single_or_cascade_config, cascade_slave,
               cascade_device_config, cascade_id, cascade_in, interrupt,
        input  control_state, interrupt_when_ack1, latch_in_service,
               end_of_acknowledge_sequence, end_of_poll_command, freeze,
               cascade_output_ack_2_3, cascade_out, cascade_io
    );

    modport slave (
        input  interrupt_acknowledge_n, read, write_initial_command_word_1, poll_command,
               u8086_or_mcs80_config, single_or_cascade_config, cascade_slave,
               cascade_device_config, cascade_id, cascade_in, interrupt,
        output control_state, interrupt_when_ack1, latch_in_service,
               end_of_acknowledge_sequence, end_of_poll_command, freeze,
               cascade_output_ack_2_3, cascade_out, cascade_io
    );
endinterface

// File: rtl/ack_sequence_controller_edge_sync_detector.sv
// Two-flop synchroniser plus one-cycle rise/fall pulses for an async strobe.
// Edge pulse appears 2 clocks after the pin changes; no backpressure.
module edge_sync_detector #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic sync_1;
    logic sync_2;
    logic hist;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= RST_VAL;
            sync_2 <= RST_VAL;
            hist   <= RST_VAL;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            hist   <= sync_2;
        end
    end

    assign rise = sync_2 & ~hist;
    assign fall = ~sync_2 & hist;
endmodule

// File: rtl/ack_sequence_controller.sv
// Sequences INTA# pulses and poll reads, latches the winning request and resolves cascade.
// State moves 3 clocks after an INTA#/read pin edge; strobes are registered, no backpressure.
module ack_sequence_controller
    import ack_sequence_controller_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset_n,
    ack_sequence_controller_if.slave   bus
);
    logic inta_rise, inta_fall, read_rise, read_fall;

    edge_sync_detector #(.RST_VAL(1'b1)) u_inta_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (bus.interrupt_acknowledge_n),
        .rise   (inta_rise),
        .fall   (inta_fall)
    );

    edge_sync_detector #(.RST_VAL(1'b0)) u_read_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (bus.read),
        .rise   (read_rise),
        .fall   (read_fall)
    );

    ctl_state_t state, next_state;
    logic       capture_next, end_ack_next, end_poll_next, eval_now;
    logic [7:0] iwa1;
    logic       latch_q, end_ack_q, end_poll_q, ack23_q;
    logic       master_mode, hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CTL_READY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        capture_next  = 1'b0;
        end_ack_next  = 1'b0;
        end_poll_next = 1'b0;
        eval_now      = 1'b0;
        if (bus.write_initial_command_word_1) begin
            next_state = CTL_READY;
        end else begin
            case (state)
                CTL_READY: begin
                    if (bus.poll_command) begin
                        next_state = POLL;
                    end else if (inta_fall) begin
                        next_state   = ACK1;
                        capture_next = 1'b1;
                    end
                end
                ACK1: begin
                    if (inta_rise) begin
                        next_state = ACK2;
                        eval_now   = 1'b1;
                    end
                end
                ACK2: begin
                    if (inta_rise) begin
                        if (bus.u8086_or_mcs80_config) begin
                            next_state = ACK3;
                        end else begin
                            next_state   = CTL_READY;
                            end_ack_next = 1'b1;
                        end
                    end
                end
                ACK3: begin
                    if (inta_rise) begin
                        next_state   = CTL_READY;
                        end_ack_next = 1'b1;
                    end
                end
                POLL: begin
                    capture_next = read_rise;
                    if (read_fall) begin
                        next_state    = CTL_READY;
                        end_poll_next = 1'b1;
                    end
                end
                default: next_state = CTL_READY;
            endcase
        end
    end

    assign master_mode = ~bus.single_or_cascade_config & ~bus.cascade_slave;
    assign hit         = |(iwa1 & bus.cascade_device_config);

    // A zero request is captured as zero so a spurious cycle never reuses a stale winner.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iwa1       <= 8'h00;
            latch_q    <= 1'b0;
            end_ack_q  <= 1'b0;
            end_poll_q <= 1'b0;
            ack23_q    <= 1'b0;
        end else begin
            latch_q    <= capture_next & (|bus.interrupt);
            end_ack_q  <= end_ack_next;
            end_poll_q <= end_poll_next;
            if (bus.write_initial_command_word_1) begin
                iwa1 <= 8'h00;
            end else if (capture_next) begin
                iwa1 <= bus.interrupt;
            end
            if (next_state == CTL_READY) begin
                ack23_q <= 1'b0;
            end else if (eval_now) begin
                if (bus.single_or_cascade_config) begin
                    ack23_q <= 1'b1;
                end else if (bus.cascade_slave) begin
                    ack23_q <= (bus.cascade_in == bus.cascade_id);
                end else begin
                    ack23_q <= ~hit;
                end
            end
        end
    end

    // The master puts the slave address on CAS2:0 from the first INTA# onward.
    assign bus.cascade_io = master_mode & hit &
                            ((state == ACK1) | (state == ACK2) | (state == ACK3));
    assign bus.cascade_out = bus.cascade_io ? bit2num(iwa1) : 3'd0;

    assign bus.control_state               = state;
    assign bus.interrupt_when_ack1         = iwa1;
    assign bus.latch_in_service            = latch_q;
    assign bus.end_of_acknowledge_sequence = end_ack_q;
    assign bus.end_of_poll_command         = end_poll_q;
    assign bus.freeze                      = (state != CTL_READY);
    assign bus.cascade_output_ack_2_3      = ack23_q;
endmodule

// File: tb/tb_ack_sequence_controller.sv
// Scoreboard bench: expected state sequence queued per scenario, checked as the DUT moves.
module tb_ack_sequence_controller;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ack_sequence_controller_if bus();
    ack_sequence_controller dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];
    logic [2:0] prev_state = 3'd0;
    int n_latch, n_end_ack, n_end_poll;
    logic [7:0] latch_val;
    logic [2:0] end_from;

    always @(negedge clock) begin
        logic [2:0] old, exp;
        old = prev_state;
        if (bus.control_state !== prev_state) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL state_seq: got state %0d, expected no transition", bus.control_state);
            end else begin
                exp = exp_q.pop_front();
                if (bus.control_state !== exp) begin
                    bad++;
                    $display("FAIL state_seq: got state %0d, expected %0d", bus.control_state, exp);
                end
            end
            prev_state = bus.control_state;
        end
        if (bus.latch_in_service === 1'b1) begin
            n_latch++;
            latch_val = bus.interrupt_when_ack1;
        end
        if (bus.end_of_acknowledge_sequence === 1'b1) begin
            n_end_ack++;
            end_from = old;
        end
        if (bus.end_of_poll_command === 1'b1) n_end_poll++;
    end

    task automatic clear_counts();
        n_latch = 0; n_end_ack = 0; n_end_poll = 0;
        latch_val = 8'h00; end_from = 3'd7;
    endtask

    task automatic inta_pulse();
        @(negedge clock) bus.interrupt_acknowledge_n = 1'b0;
        repeat (4) @(negedge clock);
        bus.interrupt_acknowledge_n = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d expected states never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic cfg(input logic mcs, input logic single, input logic slave,
                       input logic [7:0] devcfg, input logic [7:0] irq);
        bus.u8086_or_mcs80_config = mcs;
        bus.single_or_cascade_config = single;
        bus.cascade_slave = slave;
        bus.cascade_device_config = devcfg;
        bus.interrupt = irq;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        total += 6;
        if (bus.control_state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d required 0", bus.control_state); end
        if (bus.interrupt_when_ack1 !== 8'h00) begin bad++; $display("FAIL rst_iwa1: got %h required 00", bus.interrupt_when_ack1); end
        if (bus.freeze !== 1'b0) begin bad++; $display("FAIL rst_freeze: got %b required 0", bus.freeze); end
        if (bus.cascade_output_ack_2_3 !== 1'b0) begin bad++; $display("FAIL rst_ack23: got %b required 0", bus.cascade_output_ack_2_3); end
        if (bus.cascade_io !== 1'b0 || bus.cascade_out !== 3'd0) begin bad++; $display("FAIL rst_cas: got io=%b out=%0d required 0/0", bus.cascade_io, bus.cascade_out); end
        if ({bus.latch_in_service, bus.end_of_acknowledge_sequence, bus.end_of_poll_command} !== 3'b000) begin
            bad++; $display("FAIL rst_strobes: got %b required 000", {bus.latch_in_service, bus.end_of_acknowledge_sequence, bus.end_of_poll_command});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_8086_single();
        clear_counts();
        cfg(1'b0, 1'b1, 1'b0, 8'h00, 8'h04);
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd0);
        inta_pulse();
        total += 2;
        if (bus.freeze !== 1'b1) begin bad++; $display("FAIL s86_freeze: got %b required 1", bus.freeze); end
        if (bus.cascade_output_ack_2_3 !== 1'b1) begin bad++; $display("FAIL s86_ack23: got %b required 1", bus.cascade_output_ack_2_3); end
        inta_pulse();
        drain("s86");
        total += 4;
        if (n_latch != 1 || latch_val !== 8'h04) begin bad++; $display("FAIL s86_latch: got n=%0d val=%h required 1/04", n_latch, latch_val); end
        if (n_end_ack != 1 || end_from !== 3'd2) begin bad++; $display("FAIL s86_end: got n=%0d from=%0d required 1/2", n_end_ack, end_from); end
        if (n_end_poll != 0) begin bad++; $display("FAIL s86_poll: got %0d required 0", n_end_poll); end
        if (bus.cascade_output_ack_2_3 !== 1'b0) begin bad++; $display("FAIL s86_ack23_idle: got %b required 0", bus.cascade_output_ack_2_3); end
    endtask

    task automatic test_mcs80();
        clear_counts();
        cfg(1'b1, 1'b1, 1'b0, 8'h00, 8'h10);
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3); exp_q.push_back(3'd0);
        inta_pulse();
        inta_pulse();
        total++;
        if (n_end_ack != 0) begin bad++; $display("FAIL m80_early_end: got %0d required 0", n_end_ack); end
        inta_pulse();
        drain("m80");
        total += 2;
        if (n_end_ack != 1 || end_from !== 3'd3) begin bad++; $display("FAIL m80_end: got n=%0d from=%0d required 1/3", n_end_ack, end_from); end
        if (n_latch != 1 || latch_val !== 8'h10) begin bad++; $display("FAIL m80_latch: got n=%0d val=%h required 1/10", n_latch, latch_val); end
    endtask

    task automatic test_master();
        clear_counts();
        cfg(1'b0, 1'b0, 1'b0, 8'h08, 8'h08);
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd0);
        inta_pulse();
        total++;
        if (bus.cascade_io !== 1'b1 || bus.cascade_out !== 3'd3 || bus.cascade_output_ack_2_3 !== 1'b0) begin
            bad++; $display("FAIL master_hit: got io=%b out=%0d ack23=%b required 1/3/0", bus.cascade_io, bus.cascade_out, bus.cascade_output_ack_2_3);
        end
        inta_pulse();
        drain("master_hit");
        total++;
        if (bus.cascade_io !== 1'b0 || bus.cascade_out !== 3'd0) begin bad++; $display("FAIL master_idle: got io=%b out=%0d required 0/0", bus.cascade_io, bus.cascade_out); end
        bus.interrupt = 8'h01;
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd0);
        inta_pulse();
        total++;
        if (bus.cascade_io !== 1'b0 || bus.cascade_output_ack_2_3 !== 1'b1) begin
            bad++; $display("FAIL master_miss: got io=%b ack23=%b required 0/1", bus.cascade_io, bus.cascade_output_ack_2_3);
        end
        inta_pulse();
        drain("master_miss");
    endtask

    task automatic test_slave();
        logic [2:0] ins [2] = '{3'd5, 3'd2};
        logic       want[2] = '{1'b1, 1'b0};
        cfg(1'b0, 1'b0, 1'b1, 8'h00, 8'h02);
        bus.cascade_id = 3'd5;
        for (int k = 0; k < 2; k++) begin
            bus.cascade_in = ins[k];
            exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd0);
            inta_pulse();
            total++;
            if (bus.cascade_output_ack_2_3 !== want[k]) begin
                bad++; $display("FAIL slave_cas%0d: got %b required %b", ins[k], bus.cascade_output_ack_2_3, want[k]);
            end
            inta_pulse();
            drain("slave");
        end
    endtask

    task automatic test_poll();
        clear_counts();
        cfg(1'b0, 1'b1, 1'b0, 8'h00, 8'h20);
        exp_q.push_back(3'd4); exp_q.push_back(3'd0);
        @(negedge clock) bus.interrupt_acknowledge_n = 1'b0;
        @(posedge clock); @(posedge clock);
        @(negedge clock) bus.poll_command = 1'b1;
        @(negedge clock) bus.poll_command = 1'b0;
        total++;
        if (bus.control_state !== 3'd4) begin bad++; $display("FAIL poll_wins: got %0d required 4", bus.control_state); end
        repeat (3) @(negedge clock);
        bus.interrupt_acknowledge_n = 1'b1;
        repeat (5) @(negedge clock);
        bus.read = 1'b1;
        repeat (4) @(negedge clock);
        bus.read = 1'b0;
        drain("poll");
        total += 3;
        if (n_latch != 1 || latch_val !== 8'h20) begin bad++; $display("FAIL poll_latch: got n=%0d val=%h required 1/20", n_latch, latch_val); end
        if (n_end_poll != 1) begin bad++; $display("FAIL poll_end: got %0d required 1", n_end_poll); end
        if (n_end_ack != 0) begin bad++; $display("FAIL poll_no_ack_end: got %0d required 0", n_end_ack); end
    endtask

    task automatic test_spurious();
        clear_counts();
        cfg(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd0);
        inta_pulse();
        inta_pulse();
        drain("spur");
        total += 2;
        if (n_latch != 0 || bus.interrupt_when_ack1 !== 8'h00) begin bad++; $display("FAIL spur_latch: got n=%0d iwa1=%h required 0/00", n_latch, bus.interrupt_when_ack1); end
        if (n_end_ack != 1) begin bad++; $display("FAIL spur_end: got %0d required 1", n_end_ack); end
    endtask

    task automatic test_icw1_abort();
        clear_counts();
        cfg(1'b1, 1'b1, 1'b0, 8'h00, 8'h40);
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd0);
        inta_pulse();
        @(negedge clock) bus.write_initial_command_word_1 = 1'b1;
        @(negedge clock) bus.write_initial_command_word_1 = 1'b0;
        total++;
        if (bus.control_state !== 3'd0 || bus.interrupt_when_ack1 !== 8'h00) begin
            bad++; $display("FAIL icw1_abort: got state=%0d iwa1=%h required 0/00", bus.control_state, bus.interrupt_when_ack1);
        end
        repeat (3) @(negedge clock);
        drain("icw1");
        total++;
        if (n_end_ack != 0 || n_end_poll != 0) begin bad++; $display("FAIL icw1_strobe: got ack=%0d poll=%0d required 0/0", n_end_ack, n_end_poll); end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        cfg(1'b1, 1'b1, 1'b0, 8'h00, 8'h80);
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3); exp_q.push_back(3'd0);
        inta_pulse();
        inta_pulse();
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (bus.control_state !== 3'd0) begin bad++; $display("FAIL rst_mid_state: got %0d required 0", bus.control_state); end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        drain("rst_mid");
        total++;
        if (n_end_ack != 0) begin bad++; $display("FAIL rst_mid_end: got %0d required 0", n_end_ack); end
    endtask

    initial begin
        bus.interrupt_acknowledge_n = 1'b1;
        bus.read = 1'b0;
        bus.write_initial_command_word_1 = 1'b0;
        bus.poll_command = 1'b0;
        bus.cascade_id = 3'd0;
        bus.cascade_in = 3'd0;
        cfg(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        clear_counts();
        test_reset();
        test_8086_single();
        test_mcs80();
        test_master();
        test_slave();
        test_poll();
        test_spurious();
        test_icw1_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
